// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - board geometry, neighbour offsets and reveal sequencer states
package game_pkg;

  localparam logic [1:0] LEVEL_EASY   = 2'd1;
  localparam logic [1:0] LEVEL_MEDIUM = 2'd2;
  localparam logic [1:0] LEVEL_HARD   = 2'd3;

  localparam logic [4:0] SIZE_EASY   = 5'd8;
  localparam logic [4:0] SIZE_MEDIUM = 5'd10;
  localparam logic [4:0] SIZE_HARD   = 5'd16;

  localparam int MAP_BITS = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Level 0 is not a real setting and falls back to the easy board.
  function automatic logic [4:0] board_size(input logic [1:0] level);
    case (level)
      LEVEL_MEDIUM: board_size = SIZE_MEDIUM;
      LEVEL_HARD:   board_size = SIZE_HARD;
      default:      board_size = SIZE_EASY;
    endcase
  endfunction

  // Offsets are 3-bit two's complement: 3'b111 = -1, 3'b000 = 0, 3'b001 = +1.
  function automatic logic [2:0] offset_dx(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: offset_dx = 3'b111;
      3'd1, 3'd6:       offset_dx = 3'b000;
      default:          offset_dx = 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] offset_dy(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: offset_dy = 3'b111;
      3'd3, 3'd4:       offset_dy = 3'b000;
      default:          offset_dy = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/neighbour_addr_gen.sv
// rtl/neighbour_addr_gen.sv - combinational neighbour address and bounds check for offset k
module neighbour_addr_gen
  import game_pkg::*;
(
  input  logic [4:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [2:0] k,
  input  logic [4:0] n,
  output logic [4:0] probe_x,
  output logic [4:0] probe_y,
  output logic       in_bounds
);

  logic [2:0] dx;
  logic [2:0] dy;
  logic [6:0] sx;
  logic [6:0] sy;

  // 7-bit sums keep -1 (bit 6 set) and 32 (bit 5 set) distinguishable from real cells.
  always_comb begin
    dx        = offset_dx(k);
    dy        = offset_dy(k);
    sx        = {2'b00, cell_x} + {{4{dx[2]}}, dx};
    sy        = {2'b00, cell_y} + {{4{dy[2]}}, dy};
    in_bounds = !sx[6] && !sy[6] &&
                (sx[5:0] < {1'b0, n}) && (sy[5:0] < {1'b0, n});
    probe_x   = sx[4:0];
    probe_y   = sy[4:0];
  end

endmodule

// File: rtl/cell_reveal_ctrl.sv
// rtl/cell_reveal_ctrl.sv - probes the 8 neighbours of a dug cell, writes the mine count,
// tracks revealed cells and pulses win when the last safe cell is revealed
module cell_reveal_ctrl
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] cell_x,
  input  logic [4:0] cell_y,
  input  logic [1:0] level,
  input  logic       new_game,
  input  logic [7:0] safe_total,
  output logic       probe_valid,
  output logic [4:0] probe_x,
  output logic [4:0] probe_y,
  input  logic       probe_mine,
  output logic       busy,
  output logic       reveal_we,
  output logic [4:0] reveal_x,
  output logic [4:0] reveal_y,
  output logic [3:0] reveal_count,
  output logic       done,
  output logic       win,
  output logic [7:0] cells_left
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_PROBE = 2'(ST_PROBE);
  localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] S_WRITE = 2'(ST_WRITE);

  logic [1:0]          state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [4:0]          cx_q, cx_d;
  logic [4:0]          cy_q, cy_d;
  logic [4:0]          n_q, n_d;
  logic                pend_q, pend_d;
  logic [3:0]          count_q, count_d;
  logic [MAP_BITS-1:0] map_q, map_d;
  logic [7:0]          left_q, left_d;

  logic [4:0] gen_x;
  logic [4:0] gen_y;
  logic       gen_inb;
  logic       in_probe;
  logic       write_en;
  logic       start_ok;
  logic [7:0] map_idx;
  logic       was_revealed;

  neighbour_addr_gen u_addr_gen (
    .cell_x    (cx_q),
    .cell_y    (cy_q),
    .k         (k_q),
    .n         (n_q),
    .probe_x   (gen_x),
    .probe_y   (gen_y),
    .in_bounds (gen_inb)
  );

  // A WRITE coinciding with reset or new_game is suppressed so aborts never leak a reveal.
  always_comb begin
    in_probe     = (state_q == S_PROBE);
    write_en     = (state_q == S_WRITE) && !new_game && !rst;
    start_ok     = (state_q == S_IDLE) && start && !new_game;
    map_idx      = {cy_q[3:0], cx_q[3:0]};
    was_revealed = map_q[map_idx];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    n_d     = n_q;
    map_d   = map_q;
    left_d  = left_q;
    // pend_q marks that last cycle's probe was in range, so its returning mine bit counts.
    pend_d  = in_probe && gen_inb;
    count_d = count_q + {3'b000, probe_mine & pend_q};

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PROBE;
          k_d     = 3'd0;
          cx_d    = cell_x;
          cy_d    = cell_y;
          n_d     = board_size(level);
          count_d = 4'd0;
        end
      end
      S_PROBE: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase

    if (write_en && !was_revealed) begin
      map_d[map_idx] = 1'b1;
      if (left_q != 8'd0) begin
        left_d = left_q - 8'd1;
      end
    end

    if (new_game) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      map_d   = '0;
      left_d  = safe_total;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      cx_q    <= 5'd0;
      cy_q    <= 5'd0;
      n_q     <= 5'd0;
      pend_q  <= 1'b0;
      count_q <= 4'd0;
      map_q   <= '0;
      left_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      map_q   <= map_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    probe_valid  = in_probe && gen_inb;
    probe_x      = probe_valid ? gen_x : 5'd0;
    probe_y      = probe_valid ? gen_y : 5'd0;
    busy         = (state_q != S_IDLE);
    reveal_we    = write_en;
    done         = write_en;
    reveal_x     = write_en ? cx_q : 5'd0;
    reveal_y     = write_en ? cy_q : 5'd0;
    reveal_count = write_en ? count_q : 4'd0;
    win          = write_en && !was_revealed && (left_q == 8'd1);
    cells_left   = left_q;
  end

endmodule

// File: tb/tb_cell_reveal_ctrl.sv
// tb/tb_cell_reveal_ctrl.sv - scoreboard bench: expected reveals queued at start, popped on reveal_we
module tb_cell_reveal_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] cell_x;
  logic [4:0] cell_y;
  logic [1:0] level;
  logic       new_game;
  logic [7:0] safe_total;
  logic       probe_valid;
  logic [4:0] probe_x;
  logic [4:0] probe_y;
  logic       probe_mine;
  logic       busy;
  logic       reveal_we;
  logic [4:0] reveal_x;
  logic [4:0] reveal_y;
  logic [3:0] reveal_count;
  logic       done;
  logic       win;
  logic [7:0] cells_left;

  cell_reveal_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .level        (level),
    .new_game     (new_game),
    .safe_total   (safe_total),
    .probe_valid  (probe_valid),
    .probe_x      (probe_x),
    .probe_y      (probe_y),
    .probe_mine   (probe_mine),
    .busy         (busy),
    .reveal_we    (reveal_we),
    .reveal_x     (reveal_x),
    .reveal_y     (reveal_y),
    .reveal_count (reveal_count),
    .done         (done),
    .win          (win),
    .cells_left   (cells_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] x;
    logic [4:0] y;
    logic [3:0] cnt;
    logic       win;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           n_checks = 0;
  int           n_errors = 0;
  int           win_cnt  = 0;
  logic [255:0] mines;
  logic [255:0] model_map;
  int           model_left;
  bit           all_mines;
  int           DX[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  int           DY[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Registered mine lookup, one cycle behind the probe address.
  always @(posedge clk)
    probe_mine <= all_mines ? 1'b1 : mines[{probe_y[3:0], probe_x[3:0]}];

  function automatic int nsize(input int lvl);
    if (lvl == 2) return 10;
    if (lvl == 3) return 16;
    return 8;
  endfunction

  function automatic bit m_inb(input int x, input int y, input int k, input int lvl);
    int nx = x + DX[k];
    int ny = y + DY[k];
    return (nx >= 0) && (ny >= 0) && (nx < nsize(lvl)) && (ny < nsize(lvl));
  endfunction

  function automatic int model_count(input int x, input int y, input int lvl);
    int c = 0;
    for (int k = 0; k < 8; k++) begin
      if (m_inb(x, y, k, lvl) && (all_mines || mines[(y + DY[k]) * 16 + (x + DX[k])]))
        c++;
    end
    return c;
  endfunction

  task automatic push_expect(input int x, input int y, input int lvl);
    exp_t ex;
    int   idx = y * 16 + x;
    ex.x   = 5'(x);
    ex.y   = 5'(y);
    ex.cnt = 4'(model_count(x, y, lvl));
    ex.win = 1'b0;
    if (!model_map[idx]) begin
      model_map[idx] = 1'b1;
      ex.win = (model_left == 1);
      if (model_left > 0) model_left--;
    end
    exp_q.push_back(ex);
  endtask

  // Called at a negedge; returns at the negedge of T+1.
  task automatic kick(input int x, input int y, input int lvl, input bit expect_write);
    start  = 1'b1;
    cell_x = 5'(x);
    cell_y = 5'(y);
    level  = 2'(lvl);
    if (expect_write) push_expect(x, y, lvl);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_game_pulse(input int total);
    new_game   = 1'b1;
    safe_total = 8'(total);
    @(negedge clk);
    new_game   = 1'b0;
    model_map  = '0;
    model_left = total;
  endtask

  task automatic do_reveal(input int x, input int y, input int lvl);
    kick(x, y, lvl, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("probe_valid", probe_valid, m_inb(x, y, k, lvl));
      if (m_inb(x, y, k, lvl)) begin
        chk("probe_x", probe_x, x + DX[k]);
        chk("probe_y", probe_y, y + DY[k]);
      end
      if (k == 0) chk("busy_first", busy, 1);
      @(negedge clk);
    end
    chk("drain_we", reveal_we, 0);
    chk("drain_busy", busy, 1);
    @(negedge clk);
    chk("write_we", reveal_we, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("cells_left", cells_left, model_left);
  endtask

  always @(negedge clk) begin
    if (win) win_cnt++;
    if (reveal_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", reveal_we, 0);
      end else begin
        e = exp_q.pop_front();
        chk("reveal_x", reveal_x, e.x);
        chk("reveal_y", reveal_y, e.y);
        chk("reveal_count", reveal_count, e.cnt);
        chk("win", win, e.win);
        chk("done", done, 1);
      end
    end else begin
      if (win) chk("win_stray", win, 0);
      if (done) chk("done_stray", done, 0);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; new_game = 1'b0; cell_x = '0; cell_y = '0;
    level = 2'd1; safe_total = '0; all_mines = 1'b0;
    mines = '0; model_map = '0; model_left = 0;
    repeat (3) @(negedge clk);
    chk("rst_probe_valid", probe_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reveal_we", reveal_we, 0);
    chk("rst_done", done, 0);
    chk("rst_win", win, 0);
    chk("rst_cells_left", cells_left, 0);
    chk("rst_reveal_count", reveal_count, 0);
    rst = 1'b0;
    @(negedge clk);

    mines[2*16+2] = 1'b1;  mines[2*16+3] = 1'b1;  mines[4*16+4] = 1'b1;
    mines[14*16+14] = 1'b1; mines[14*16+15] = 1'b1;
    mines[1*16+8] = 1'b1;  mines[1*16+9] = 1'b1;
    mines[0] = 1'b1;       mines[8*16+8] = 1'b1;

    new_game_pulse(54);
    chk("ng_cells_left", cells_left, 54);
    do_reveal(3, 3, 1);
    all_mines = 1'b1;
    do_reveal(0, 0, 1);
    all_mines = 1'b0;
    do_reveal(15, 15, 3);
    do_reveal(9, 0, 2);
    do_reveal(7, 7, 0);
    do_reveal(5, 5, 1);
    do_reveal(5, 5, 1);

    new_game_pulse(2);
    win_cnt = 0;
    do_reveal(1, 1, 1);
    do_reveal(2, 1, 1);
    do_reveal(3, 1, 1);
    chk("win_pulses", win_cnt, 1);

    // Reset at T+4
    new_game_pulse(50);
    kick(4, 4, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_map = '0;
    model_left = 0;
    chk("midrst_probe_valid", probe_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_reveal_we", reveal_we, 0);
    chk("midrst_cells_left", cells_left, 0);
    chk("midrst_probe_x", probe_x, 0);
    repeat (12) @(negedge clk);
    chk("midrst_idle", busy, 0);

    // new_game at T+6
    new_game_pulse(40);
    kick(4, 4, 1, 1'b0);
    repeat (5) @(negedge clk);
    new_game_pulse(30);
    chk("midng_busy", busy, 0);
    chk("midng_cells_left", cells_left, 30);
    repeat (12) @(negedge clk);
    chk("midng_cells_left_hold", cells_left, 30);

    // start at T+3 is ignored
    kick(6, 6, 1, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; cell_x = 5'd1; cell_y = 5'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_start_write", reveal_we, 1);
    @(negedge clk);
    chk("busy_start_idle", busy, 0);
    repeat (12) @(negedge clk);
    chk("busy_start_still_idle", busy, 0);
    chk("busy_start_cells_left", cells_left, model_left);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
